// File: rtl/multicycle_pkg.sv
// Shared types for the multi-cycle RV32I control sequencer: state encoding,
// opcode constants and datapath select encodings.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_A = 2'b10} alu_src_a_t;
  typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10} alu_src_b_t;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MDR = 2'b01, RES_ALU = 2'b10} result_src_t;
  typedef enum logic [1:0] {TRAP_NONE = 2'b00, TRAP_ILLEGAL = 2'b01, TRAP_TIMEOUT = 2'b10} trap_cause_t;

  // States that present a request on the shared memory port.
  function automatic logic is_req_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Request/ready handshake between the control sequencer and the unified memory port.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, mem_we, iord, input mem_ready);
  modport slave  (input mem_req, mem_we, iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory watchdog: counts consecutive wait cycles of a pending request and
// flags expiry when the LIMIT-th wait cycle is seen; LIMIT of 0 disables it.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 0,
  parameter int unsigned CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expire_c
);

  logic [CNT_W-1:0] cnt;

  // Saturating counter; cleared whenever no request is waiting.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  if (LIMIT == 0) begin : g_off
    assign expire_c = 1'b0;
  end else begin : g_on
    assign expire_c = count && (cnt >= CNT_W'(LIMIT - 1));
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle RV32I datapath with a shared memory port.
// Optional MULTICYCLE_PERF_EN adds cycle/instret/stall performance counters.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_if.master    bus,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  output logic                 ir_write,
  output logic                 pc_en,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 reg_write,
  output logic                 halted,
  output logic [1:0]           trap_cause,
  output logic [3:0]           state
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt,
  output logic [CNT_W-1:0]     stall_cnt
`endif
);

  state_t      state_q, state_d;
  trap_cause_t trap_q, trap_d;
  logic        wait_c;
  logic        expire_c;

  assign wait_c = is_req_state(state_q) && !bus.mem_ready;

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (!wait_c),
    .count    (wait_c),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      trap_q  <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
    end
  end

  // Next state and datapath controls; everything forced low while in reset.
  always_comb begin
    state_d     = state_q;
    trap_d      = trap_q;
    bus.mem_req = is_req_state(state_q);
    bus.mem_we  = 1'b0;
    bus.iord    = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_B;
    alu_op      = ALU_ADD;
    result_src  = RES_ALUOUT;
    reg_write   = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d = S_TRAP;
            trap_d  = TRAP_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MDR;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        bus.mem_we = 1'b1;
        bus.iord   = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_A;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_A;
        alu_op    = ALU_SUB;
        pc_en     = zero;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_en     = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Watchdog only fires while a request is still waiting, so ready wins.
    if (expire_c) begin
      state_d = S_TRAP;
      trap_d  = TRAP_TIMEOUT;
    end
    if (reset) begin
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      bus.iord    = 1'b0;
      ir_write    = 1'b0;
      pc_en       = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      result_src  = 2'b00;
      reg_write   = 1'b0;
      halted      = 1'b0;
    end
  end

  assign state      = reset ? 4'd0 : state_q;
  assign trap_cause = reset ? 2'b00 : trap_q;

`ifdef MULTICYCLE_PERF_EN
  logic [CNT_W-1:0] cyc_q, ret_q, stl_q;

  // Free-running counters, frozen once the core has halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
      stl_q <= '0;
    end else if (state_q != S_TRAP) begin
      cyc_q <= cyc_q + CNT_W'(1);
      if ((state_d == S_FETCH) && (state_q != S_FETCH)) ret_q <= ret_q + CNT_W'(1);
      if (wait_c) stl_q <= stl_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = reset ? '0 : cyc_q;
  assign instret_cnt = reset ? '0 : ret_q;
  assign stall_cnt   = reset ? '0 : stl_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus a random instruction stream
// checked against per-instruction-class cycle and strobe counts.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  localparam int unsigned TMO = 8;
  localparam int unsigned CW  = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       ir_write, pc_en, reg_write, halted;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, trap_cause;
  logic [3:0] state;
`ifdef MULTICYCLE_PERF_EN
  logic [CW-1:0] cycle_cnt, instret_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .opcode     (opcode),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .reg_write  (reg_write),
    .halted     (halted),
    .trap_cause (trap_cause),
    .state      (state)
`ifdef MULTICYCLE_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [20:0] all_out;
  assign all_out = {bus.mem_req, bus.mem_we, bus.iord, ir_write, pc_en, alu_src_a, alu_src_b,
                    alu_op, result_src, reg_write, halted, trap_cause, state};

  // Per-instruction observations gathered by run_instr.
  int          n_cyc, n_regw, n_pce, n_pce_fetch, n_irw, n_we, n_iord, n_req, n_unstable;
  logic [1:0]  res_wb;
  logic [3:0]  regw_state;
  logic [63:0] seq_sig;
  bit          run_ok;

  // Reference rules: cycle counts per class with zero-wait memory plus wait cycles.
  function automatic bit is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic int exp_cycles(input logic [6:0] op, input int fw, input int mw);
    int b;
    b = (op == OP_LOAD) ? 5 : (op == OP_BRANCH) ? 3 : 4;
    return b + fw + (is_mem(op) ? mw : 0);
  endfunction

  // Starts at a negedge in FETCH; memory answers after fw (fetch) / mw (data) wait cycles.
  task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw,
                           input bit tie);
    int         left;
    bit         left_fetch;
    bit         pr_wait;
    logic [2:0] pr;
    left = fw; left_fetch = 0; pr_wait = 0; pr = '0;
    n_cyc = 0; n_regw = 0; n_pce = 0; n_pce_fetch = 0; n_irw = 0;
    n_we = 0; n_iord = 0; n_req = 0; n_unstable = 0;
    res_wb = 2'b11; regw_state = 4'hf; seq_sig = '0; run_ok = 0;
    opcode = op; zero = z;
    for (int c = 0; c < 64; c++) begin
      if (state != 4'd0) left_fetch = 1;
      else if (left_fetch) begin
        run_ok = 1;
        break;
      end
      if (tie) bus.mem_ready = 1'b1;
      else if (bus.mem_req) bus.mem_ready = (left == 0);
      else bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      n_cyc++;
      seq_sig = {seq_sig[59:0], state};
      if (reg_write) begin n_regw++; res_wb = result_src; regw_state = state; end
      if (pc_en) begin n_pce++; if (state == 4'd0) n_pce_fetch++; end
      if (ir_write) n_irw++;
      if (bus.mem_we) n_we++;
      if (bus.mem_req && bus.iord) n_iord++;
      if (bus.mem_req) n_req++;
      if (pr_wait && ({bus.mem_req, bus.mem_we, bus.iord} != pr)) n_unstable++;
      pr_wait = bus.mem_req && !bus.mem_ready;
      pr = {bus.mem_req, bus.mem_we, bus.iord};
      if (bus.mem_req && !tie) left = bus.mem_ready ? mw : left - 1;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.mem_ready = 1'b1; opcode = OP_LOAD; zero = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rst_cycle0 got %h exp 0", all_out); end
    @(negedge clk); #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rst_cycle1 got %h exp 0", all_out); end
    @(negedge clk);
    reset = 1'b0; bus.mem_ready = 1'b0;
    #1;
    checks++;
    if ({state, bus.mem_req, bus.iord, alu_src_a, alu_src_b, alu_op, result_src,
         ir_write, pc_en, reg_write, halted} !==
        {4'd0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 2'b10, 4'b0000}) begin
      errors++;
      $display("FAIL fetch_outputs got st=%0d req=%b iord=%b a=%b b=%b op=%b rs=%b irw=%b pce=%b",
               state, bus.mem_req, bus.iord, alu_src_a, alu_src_b, alu_op, result_src, ir_write, pc_en);
    end
    checks++;
    if (trap_cause !== 2'b00) begin errors++; $display("FAIL rst_cause got %b exp 00", trap_cause); end
  endtask

  task automatic test_rtype();
    run_instr(OP_RTYPE, 1'b0, 0, 0, 1'b1);
    checks++;
    if (!run_ok || seq_sig !== 64'h0168) begin errors++; $display("FAIL rtype_seq got %h exp 0168", seq_sig); end
    checks++;
    if (n_regw !== 1 || regw_state !== 4'd8) begin
      errors++; $display("FAIL rtype_regw got n=%0d st=%0d exp n=1 st=8", n_regw, regw_state);
    end
    checks++;
    if (n_pce !== 1 || n_pce_fetch !== 1) begin
      errors++; $display("FAIL rtype_pce got n=%0d fetch=%0d exp 1/1", n_pce, n_pce_fetch);
    end
  endtask

  task automatic test_load_wait();
    run_instr(OP_LOAD, 1'b0, 0, 3, 1'b0);
    checks++;
    if (n_cyc !== 8) begin errors++; $display("FAIL load_cycles got %0d exp 8", n_cyc); end
    checks++;
    if (seq_sig !== 64'h01233334) begin errors++; $display("FAIL load_seq got %h exp 01233334", seq_sig); end
    checks++;
    if (n_iord !== 4 || n_req !== 5 || n_unstable !== 0) begin
      errors++; $display("FAIL load_req got iord=%0d req=%0d unst=%0d exp 4/5/0", n_iord, n_req, n_unstable);
    end
    checks++;
    if (n_regw !== 1 || res_wb !== 2'b01) begin
      errors++; $display("FAIL load_wb got n=%0d rs=%b exp 1/01", n_regw, res_wb);
    end
  endtask

  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      run_instr(OP_BRANCH, 1'(z), 0, 0, 1'b0);
      checks++;
      if (!run_ok || seq_sig !== 64'h019) begin errors++; $display("FAIL branch_seq z=%0d got %h exp 019", z, seq_sig); end
      checks++;
      if (n_pce - n_pce_fetch !== z) begin
        errors++; $display("FAIL branch_pce z=%0d got %0d exp %0d", z, n_pce - n_pce_fetch, z);
      end
    end
  endtask

  task automatic test_illegal();
    int bad;
`ifdef MULTICYCLE_PERF_EN
    logic [CW-1:0] snap;
`endif
    opcode = 7'b0000000; zero = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL ill_decode got %0d exp 1", state); end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd11 || halted !== 1'b1 || trap_cause !== 2'b01) begin
      errors++; $display("FAIL ill_trap got st=%0d h=%b c=%b exp 11/1/01", state, halted, trap_cause);
    end
`ifdef MULTICYCLE_PERF_EN
    snap = cycle_cnt;
`endif
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.mem_req || state != 4'd11 || trap_cause != 2'b01 || !halted) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ill_sticky got %0d bad cycles exp 0", bad); end
`ifdef MULTICYCLE_PERF_EN
    checks++;
    if (cycle_cnt !== snap) begin errors++; $display("FAIL ill_freeze got %0d exp %0d", cycle_cnt, snap); end
`endif
    do_reset(1);
    #1;
    checks++;
    if (state !== 4'd0 || trap_cause !== 2'b00 || halted !== 1'b0) begin
      errors++; $display("FAIL ill_reset got st=%0d c=%b h=%b exp 0/00/0", state, trap_cause, halted);
    end
  endtask

  task automatic test_timeout();
    int bad;
    opcode = OP_RTYPE; bus.mem_ready = 1'b0; bad = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (state != 4'd0 || !bus.mem_req) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL tmo_wait got %0d bad cycles exp 0", bad); end
    #1;
    checks++;
    if (state !== 4'd11 || trap_cause !== 2'b10) begin
      errors++; $display("FAIL tmo_trap got st=%0d c=%b exp 11/10", state, trap_cause);
    end
    do_reset(1);
    for (int c = 0; c < 7; c++) @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || ir_write !== 1'b1) begin
      errors++; $display("FAIL tmo_edge_fetch got st=%0d irw=%b exp 0/1", state, ir_write);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd1 || trap_cause !== 2'b00) begin
      errors++; $display("FAIL tmo_edge_decode got st=%0d c=%b exp 1/00", state, trap_cause);
    end
  endtask

  task automatic test_reset_mid_memwr();
    do_reset(1);
    opcode = OP_STORE; bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd5 || bus.mem_we !== 1'b1 || bus.iord !== 1'b1) begin
      errors++; $display("FAIL memwr_enter got st=%0d we=%b iord=%b exp 5/1/1", state, bus.mem_we, bus.iord);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL memwr_rst_now got %h exp 0", all_out); end
    @(negedge clk); #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL memwr_rst_next got %h exp 0", all_out); end
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || bus.mem_we !== 1'b0 || bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL memwr_release got st=%0d we=%b req=%b exp 0/0/1", state, bus.mem_we, bus.mem_req);
    end
`ifdef MULTICYCLE_PERF_EN
    checks++;
    if (cycle_cnt !== '0 || instret_cnt !== '0 || stall_cnt !== '0) begin
      errors++; $display("FAIL memwr_counters got %0d/%0d/%0d exp 0/0/0", cycle_cnt, instret_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    logic [6:0] op;
    logic       z;
    int         fw, mw, ec, tot_cyc, tot_stall;
    ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL};
    tot_cyc = 0; tot_stall = 0;
    do_reset(2);
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 5)];
      z  = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      run_instr(op, z, fw, mw, 1'b0);
      ec = exp_cycles(op, fw, mw);
      tot_cyc += ec;
      tot_stall += fw + (is_mem(op) ? mw : 0);
      checks++;
      if (!run_ok || n_cyc !== ec) begin
        errors++; $display("FAIL rand_cycles[%0d] op=%b got %0d exp %0d", i, op, n_cyc, ec);
      end
      checks++;
      if (n_regw !== ((op == OP_STORE || op == OP_BRANCH) ? 0 : 1) ||
          (n_regw == 1 && res_wb !== ((op == OP_LOAD) ? 2'b01 : 2'b00))) begin
        errors++; $display("FAIL rand_regw[%0d] op=%b got n=%0d rs=%b", i, op, n_regw, res_wb);
      end
      checks++;
      if (n_pce !== 1 + ((op == OP_BRANCH && z) ? 1 : 0) + ((op == OP_JAL) ? 1 : 0) || n_irw !== 1) begin
        errors++; $display("FAIL rand_pc[%0d] op=%b z=%b got pce=%0d irw=%0d", i, op, z, n_pce, n_irw);
      end
      checks++;
      if (n_req !== fw + 1 + (is_mem(op) ? mw + 1 : 0) ||
          n_we !== ((op == OP_STORE) ? mw + 1 : 0) || n_unstable !== 0) begin
        errors++; $display("FAIL rand_mem[%0d] op=%b got req=%0d we=%0d unst=%0d fw=%0d mw=%0d",
                           i, op, n_req, n_we, n_unstable, fw, mw);
      end
    end
`ifdef MULTICYCLE_PERF_EN
    checks++;
    if (cycle_cnt !== CW'(tot_cyc) || instret_cnt !== CW'(40) || stall_cnt !== CW'(tot_stall)) begin
      errors++; $display("FAIL rand_perf got %0d/%0d/%0d exp %0d/40/%0d",
                         cycle_cnt, instret_cnt, stall_cnt, tot_cyc, tot_stall);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; opcode = '0; zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_memwr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core. It replaces the combinational opcode decoder and lets one ALU and one unified instruction/data memory port be shared across successive cycles. A Moore FSM sequences fetch, decode, execute, memory and writeback, with a req/ready handshake to the memory. It sits beside the datapath (PC, IR, A/B/ALUOut/MDR registers, ALU control) and drives every enable and mux select.

Parameters:
MEM_TIMEOUT, 0, max cycles mem_req may wait for mem_ready before trapping; 0 disables the watchdog.
CNT_W, 32, width of the performance counters and the watchdog counter.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
opcode  input  7  IR[6:0]; sampled in DECODE
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current request this cycle
mem_req  output  1  memory request valid
mem_we  output  1  request is a write
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  output  1  load IR and OldPC
pc_en  output  1  PC load enable: unconditional write, or branch write gated by zero
alu_src_a  output  2  00 PC, 01 OldPC, 10 A register
alu_src_b  output  2  00 B register, 01 constant 4, 10 immediate
alu_op  output  2  00 add, 01 sub, 10 decode by funct fields
result_src  output  2  00 ALUOut, 01 MDR, 10 ALU result
reg_write  output  1  register file write enable
halted  output  1  FSM is in TRAP
trap_cause  output  2  00 none, 01 illegal opcode, 10 memory timeout
state  output  4  current state, for debug

Behaviour:
- Reset: synchronous; the state register goes to FETCH. While reset is high, every output is 0 (state and trap_cause included). Reset wins over any pending handshake, including mid-MEMWR.
- Outputs are combinational from state; pc_en additionally uses zero.
- States and encodings, with outputs and transitions:
  - FETCH 0: mem_req=1, iord=0, srcA=00, srcB=01, alu_op=00, result_src=10. On mem_ready: ir_write=1, pc_en=1, go to DECODE. Otherwise hold, with all strobes 0.
  - DECODE 1: srcA=01, srcB=10, alu_op=00 (branch/JAL target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other opcode -> TRAP, cause 01
  - MEMADR 2: srcA=10, srcB=10, alu_op=00. Load -> MEMRD; store -> MEMWR (opcode is held stable by IR).
  - MEMRD 3: mem_req=1, iord=1. On mem_ready -> MEMWB.
  - MEMWB 4: result_src=01, reg_write=1 -> FETCH.
  - MEMWR 5: mem_req=1, mem_we=1, iord=1. On mem_ready -> FETCH.
  - EXEC_R 6: srcA=10, srcB=00, alu_op=10 -> ALUWB.
  - EXEC_I 7: srcA=10, srcB=10, alu_op=10 -> ALUWB.
  - ALUWB 8: result_src=00, reg_write=1 -> FETCH.
  - BRANCH 9: srcA=10, srcB=00, alu_op=01, result_src=00, pc_en=zero -> FETCH.
  - JAL 10: srcA=01, srcB=01, alu_op=00, result_src=00, pc_en=1 -> ALUWB.
  - TRAP 11: halted=1, all strobes 0. Sticky until reset; trap_cause holds its value.
- Handshake rules:
  - mem_req, mem_we and iord stay stable until the cycle in which mem_ready=1 while requesting.
  - mem_ready is ignored whenever mem_req=0.
  - Exactly one request completes per ready cycle.
- Cycle counts with zero-wait memory: load 5, store/R/I/JAL 4, branch 3. Each wait cycle adds 1.
- Watchdog (MEM_TIMEOUT>0):
  - The counter clears on entry to any request state and increments each cycle with mem_req & !mem_ready.
  - When it reaches MEM_TIMEOUT with ready still low, the next state is TRAP, cause 10.
  - mem_ready arriving in the same cycle as the limit completes normally; ready has priority.
  - The counter saturates and never wraps.

Optional Feature:
MULTICYCLE_PERF_EN
- Defined: adds outputs cycle_cnt, instret_cnt and stall_cnt, each CNT_W bits, all cleared by reset.
  - cycle_cnt increments every non-reset cycle while not halted.
  - instret_cnt increments in every cycle whose next state is FETCH and whose current state is not FETCH.
  - stall_cnt increments each cycle with mem_req & !mem_ready.
  - All three wrap modulo 2^CNT_W and freeze in TRAP.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package multicycle_pkg holds:
  - the state enum (4 bits, encodings above);
  - opcode constants;
  - ALU_SRC_A, ALU_SRC_B, ALU_OP, RESULT_SRC and TRAP_CAUSE encodings.
- One sub-module, mem_wait_timer: the watchdog counter with clear, count and expire.

Test Plan:
- Reset for 2 cycles, then R-type 0110011 with mem_ready tied high -> states 0,1,6,8,0; reg_write high exactly 1 cycle (state 8); pc_en high only in FETCH.
- Load 0000011 with mem_ready low for 3 cycles in MEMRD -> mem_req=1, iord=1 held 4 cycles; MEMWB result_src=01 with reg_write=1; 8 cycles total.
- Branch 1100011: zero=1 -> pc_en=1 in BRANCH; repeat with zero=0 -> pc_en=0; next state FETCH in both cases.
- Opcode 0000000 -> TRAP after DECODE, halted=1, trap_cause=01, no mem_req for 20 cycles; reset -> FETCH with trap_cause=00.
- MEM_TIMEOUT=8, mem_ready held low in FETCH -> TRAP with cause 10 after 8 wait cycles; variant with ready on the 8th cycle -> DECODE, no trap.
- Reset asserted mid-MEMWR with ready low -> next cycle all outputs 0; after release FETCH, mem_we=0; with MULTICYCLE_PERF_EN defined, all counters read 0.
